divider_seq: RTL and testbench

DIVIDER_SEQ -- requirements
Module: divider_seq

---
 rtl/divider_seq_pkg.sv | 19 +
 rtl/divider_seq_step.sv | 30 +++
 rtl/divider_seq.sv | 203 ++++++++++++++++++++
 tb/tb_divider_seq.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/divider_seq_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding
// and the helper that derives the number of CALC cycles.
package dividerPkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_e;

    // Number of CALC cycles needed to retire all quotient bits.
    function automatic int calc_steps(input int width, input int bpc);
        return width / bpc;
    endfunction

endpackage

// File: rtl/divider_seq_step.sv
// One radix-2 restoring division step (purely combinational).
// Ports: rem_i/quo_i/div_i in, rem_o/quo_o out.
//   rem_i : partial remainder (always < divisor)
//   quo_i : dividend bits still to shift in (MSB first); quotient bits
//           accumulate at the LSB end as the dividend shifts out
//   div_i : divisor magnitude
module divider_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           neg;

    assign shifted = {rem_i, quo_i[WIDTH-1]};
    assign trial   = shifted - {1'b0, div_i};

    // Because rem_i < div_i, the shifted value is below 2*div_i, so the
    // extra bit of the trial difference is a reliable sign bit.
    assign neg   = trial[WIDTH];
    assign rem_o = neg ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_o = {quo_i[WIDTH-2:0], ~neg};

endmodule

// File: rtl/divider_seq.sv
// Sequential restoring divider, signed or unsigned, BITS_PER_CYCLE
// quotient bits per cycle, valid/ready on both request and result.
// Ports: i_clk, i_rst (async, active-high), i_cg (clock-gate enable);
//   request  : i_valid/o_ready, i_signed, i_dividend, i_divisor
//   response : o_valid/i_ready, o_quotient, o_remainder,
//              o_divZero, o_overflow
module divider_seq
    import dividerPkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int BITS_PER_CYCLE = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cg,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_divZero,
    output logic             o_overflow
);

    localparam int N  = calc_steps(WIDTH, BITS_PER_CYCLE);
    localparam int CW = $clog2(N) + 1;
    localparam logic [CW-1:0]    LAST    = CW'(N);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    if ((WIDTH < 4) || ((WIDTH % 2) != 0)) begin : g_bad_width
        $error("divider_seq: WIDTH must be even and >= 4");
    end
    if (!((BITS_PER_CYCLE == 1) || (BITS_PER_CYCLE == 2) ||
          (BITS_PER_CYCLE == 4)) || ((WIDTH % BITS_PER_CYCLE) != 0))
    begin : g_bad_bpc
        $error("divider_seq: BITS_PER_CYCLE must be 1, 2 or 4 and divide WIDTH");
    end

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic             negq_q, negq_d;
    logic             negr_q, negr_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] resq_q, resq_d;
    logic [WIDTH-1:0] resr_q, resr_d;
    logic             rdz_q, rdz_d;
    logic             rov_q, rov_d;

    // Chained single-bit steps; one CALC cycle walks the whole chain.
    logic [WIDTH-1:0] rem_c [BITS_PER_CYCLE+1];
    logic [WIDTH-1:0] quo_c [BITS_PER_CYCLE+1];

    assign rem_c[0] = rem_q;
    assign quo_c[0] = quo_q;

    for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
        divider_step #(.WIDTH(WIDTH)) u_step (
            .rem_i (rem_c[g]),
            .quo_i (quo_c[g]),
            .div_i (dvs_q),
            .rem_o (rem_c[g+1]),
            .quo_o (quo_c[g+1])
        );
    end

    assign o_ready     = (state_q == S_IDLE) ||
                         ((state_q == S_DONE) && i_ready);
    assign o_valid     = (state_q == S_DONE);
    assign o_quotient  = resq_q;
    assign o_remainder = resr_q;
    assign o_divZero   = rdz_q;
    assign o_overflow  = rov_q;

    logic load;
    logic dvd_neg;
    logic dvs_neg;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        dvd_d   = dvd_q;
        negq_d  = negq_q;
        negr_d  = negr_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        resq_d  = resq_q;
        resr_d  = resr_q;
        rdz_d   = rdz_q;
        rov_d   = rov_q;
        load    = 1'b0;
        dvd_neg = i_signed & i_dividend[WIDTH-1];
        dvs_neg = i_signed & i_divisor[WIDTH-1];

        if (i_cg) begin
            unique case (state_q)
                S_IDLE: begin
                    load = i_valid;
                end
                S_CALC: begin
                    // Count reaches N one cycle after the last step, which
                    // gives the fixed accept-to-valid latency of N+2.
                    if (cnt_q == LAST) begin
                        state_d = S_FIX;
                    end else begin
                        rem_d = rem_c[BITS_PER_CYCLE];
                        quo_d = quo_c[BITS_PER_CYCLE];
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_FIX: begin
                    state_d = S_DONE;
                    cnt_d   = '0;
                    if (zero_q) begin
                        resq_d = '1;
                        resr_d = dvd_q;
                        rdz_d  = 1'b1;
                        rov_d  = 1'b0;
                    end else if (ovf_q) begin
                        resq_d = dvd_q;
                        resr_d = '0;
                        rdz_d  = 1'b0;
                        rov_d  = 1'b1;
                    end else begin
                        resq_d = negq_q ? -quo_q : quo_q;
                        resr_d = negr_q ? -rem_q : rem_q;
                        rdz_d  = 1'b0;
                        rov_d  = 1'b0;
                    end
                end
                S_DONE: begin
                    if (i_ready) begin
                        if (i_valid) begin
                            load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
            endcase
        end

        if (load) begin
            state_d = S_CALC;
            cnt_d   = '0;
            rem_d   = '0;
            quo_d   = dvd_neg ? -i_dividend : i_dividend;
            dvs_d   = dvs_neg ? -i_divisor : i_divisor;
            dvd_d   = i_dividend;
            negq_d  = dvd_neg ^ dvs_neg;
            negr_d  = dvd_neg;
            zero_d  = (i_divisor == '0);
            ovf_d   = i_signed && (i_dividend == MOST_NEG) &&
                      (i_divisor == '1);
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            dvd_q   <= '0;
            negq_q  <= 1'b0;
            negr_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            resq_q  <= '0;
            resr_q  <= '0;
            rdz_q   <= 1'b0;
            rov_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            dvd_q   <= dvd_d;
            negq_q  <= negq_d;
            negr_q  <= negr_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            resq_q  <= resq_d;
            resr_q  <= resr_d;
            rdz_q   <= rdz_d;
            rov_q   <= rov_d;
        end
    end

endmodule

// File: tb/tb_divider_seq.sv
// Scoreboard bench for divider_seq: three instances (1, 2, 4 bits per
// cycle), directed corner cases plus a randomized sweep with clock gating.
module tb_divider_seq;

    localparam int W = 8;

    typedef struct {
        logic [7:0] q;
        logic [7:0] r;
        logic       dz;
        logic       ov;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cg  = 1'b1;
    bit         cg_rand = 1'b0;

    logic       vld   [3];
    logic       rdy_o [3];
    logic       sgn   [3];
    logic       ovld  [3];
    logic       rdy_i [3];
    logic       dz    [3];
    logic       ov    [3];
    logic [7:0] dvd   [3];
    logic [7:0] dvs   [3];
    logic [7:0] quo   [3];
    logic [7:0] rem   [3];

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    // Counts only enabled edges, so latency is measured in active cycles.
    always @(posedge clk) if (cg) cyc <= cyc + 1;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            cg = cg_rand ? (($urandom % 5) != 0) : 1'b1;
        end
    end

    // Reference: plain integer division semantics.
    function automatic exp_t model(logic s, logic [7:0] a, logic [7:0] b);
        exp_t e;
        int   x;
        int   y;
        e.acc = 0;
        e.dz  = 1'b0;
        e.ov  = 1'b0;
        if (b == 8'd0) begin
            e.q  = 8'hFF;
            e.r  = a;
            e.dz = 1'b1;
        end else if (!s) begin
            e.q = a / b;
            e.r = a % b;
        end else begin
            x = int'($signed(a));
            y = int'($signed(b));
            if (x == -128 && y == -1) begin
                e.q  = a;
                e.r  = 8'd0;
                e.ov = 1'b1;
            end else begin
                e.q = 8'(x / y);
                e.r = 8'(x % y);
            end
        end
        return e;
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at t=%0t",
                     nm, act, act, exp, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int BPC = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
        localparam int LAT = W / BPC + 2;

        exp_t scb[$];
        exp_t cur;
        bit   have = 1'b0;

        divider_seq #(.WIDTH(W), .BITS_PER_CYCLE(BPC)) u_dut (
            .i_clk       (clk),
            .i_rst       (rst),
            .i_cg        (cg),
            .i_valid     (vld[g]),
            .o_ready     (rdy_o[g]),
            .i_signed    (sgn[g]),
            .i_dividend  (dvd[g]),
            .i_divisor   (dvs[g]),
            .o_valid     (ovld[g]),
            .i_ready     (rdy_i[g]),
            .o_quotient  (quo[g]),
            .o_remainder (rem[g]),
            .o_divZero   (dz[g]),
            .o_overflow  (ov[g])
        );

        always @(negedge clk) begin
            exp_t e;
            if (rst) begin
                scb.delete();
                have = 1'b0;
            end else begin
                if (ovld[g]) begin
                    if (!have) begin
                        if (scb.size() == 0) begin
                            chk($sformatf("unexpected_result[%0d]", g), 1, 0);
                        end else begin
                            cur  = scb.pop_front();
                            have = 1'b1;
                            chk($sformatf("latency[%0d]", g),
                                cyc - cur.acc - 1, LAT);
                        end
                    end
                    if (have) begin
                        chk($sformatf("quotient[%0d]", g), int'(quo[g]), int'(cur.q));
                        chk($sformatf("remainder[%0d]", g), int'(rem[g]), int'(cur.r));
                        chk($sformatf("divZero[%0d]", g), int'(dz[g]), int'(cur.dz));
                        chk($sformatf("overflow[%0d]", g), int'(ov[g]), int'(cur.ov));
                    end
                    if (rdy_i[g] && cg) have = 1'b0;
                end
                if (vld[g] && rdy_o[g] && cg) begin
                    e     = model(sgn[g], dvd[g], dvs[g]);
                    e.acc = cyc;
                    scb.push_back(e);
                end
            end
        end
    end

    task automatic wait_hs(int k);
        bit hs;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            hs = vld[k] && rdy_o[k] && cg;
            @(posedge clk);
            #1;
            ok = hs;
        end
        if (!ok) chk($sformatf("accept_timeout[%0d]", k), 0, 1);
    endtask

    task automatic accept_op(int k, logic s, logic [7:0] a, logic [7:0] b);
        sgn[k] = s;
        dvd[k] = a;
        dvs[k] = b;
        vld[k] = 1'b1;
        wait_hs(k);
        vld[k] = 1'b0;
    endtask

    task automatic wait_valid(int k);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = ovld[k];
        end
        if (!ok) chk($sformatf("result_timeout[%0d]", k), 0, 1);
        @(posedge clk);
        #1;
    endtask

    // Consume the result; optionally present a new request on the same edge.
    task automatic release_res(int k, bit b2b, logic s,
                               logic [7:0] a, logic [7:0] b);
        bit hs;
        bit ok;
        rdy_i[k] = 1'b1;
        if (b2b) begin
            sgn[k] = s;
            dvd[k] = a;
            dvs[k] = b;
            vld[k] = 1'b1;
        end
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            hs = ovld[k] && rdy_i[k] && cg;
            if (b2b && hs) chk($sformatf("b2b_ready[%0d]", k), int'(rdy_o[k]), 1);
            @(posedge clk);
            #1;
            ok = hs;
        end
        if (!ok) chk($sformatf("consume_timeout[%0d]", k), 0, 1);
        rdy_i[k] = 1'b0;
        vld[k]   = 1'b0;
    endtask

    task automatic run_op(int k, logic s, logic [7:0] a, logic [7:0] b, int h);
        accept_op(k, s, a, b);
        wait_valid(k);
        repeat (h) begin
            @(posedge clk);
            #1;
        end
        release_res(k, 1'b0, 1'b0, 8'd0, 8'd0);
    endtask

    task automatic rnd_op(output logic s, output logic [7:0] a,
                          output logic [7:0] b);
        s = 1'($urandom % 2);
        a = 8'($urandom);
        b = 8'($urandom);
        case ($urandom % 8)
            0: b = 8'h00;
            1: b = 8'hFF;
            2: begin
                a = 8'h80;
                b = 8'hFF;
            end
            3: b = 8'($urandom % 4);
            default: ;
        endcase
    endtask

    initial begin
        logic       s;
        logic [7:0] a;
        logic [7:0] b;
        bit         bb;

        for (int k = 0; k < 3; k++) begin
            vld[k]   = 1'b0;
            sgn[k]   = 1'b0;
            dvd[k]   = 8'd0;
            dvs[k]   = 8'd0;
            rdy_i[k] = 1'b0;
        end

        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_ready[%0d]", k), int'(rdy_o[k]), 1);
            chk($sformatf("rst_valid[%0d]", k), int'(ovld[k]), 0);
            chk($sformatf("rst_quo[%0d]", k), int'(quo[k]), 0);
            chk($sformatf("rst_rem[%0d]", k), int'(rem[k]), 0);
            chk($sformatf("rst_dz[%0d]", k), int'(dz[k]), 0);
            chk($sformatf("rst_ov[%0d]", k), int'(ov[k]), 0);
        end
        rst = 1'b0;

        run_op(0, 1'b0, 8'd200, 8'd7, 0);
        run_op(0, 1'b1, 8'hF9, 8'h02, 1);
        run_op(0, 1'b1, 8'h07, 8'hFE, 0);
        run_op(0, 1'b0, 8'd13, 8'h00, 0);
        run_op(0, 1'b1, 8'h80, 8'hFF, 0);
        run_op(0, 1'b1, 8'h85, 8'h00, 0);

        accept_op(0, 1'b0, 8'd100, 8'd3);
        wait_valid(0);
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        release_res(0, 1'b1, 1'b0, 8'd77, 8'd5);
        wait_valid(0);
        release_res(0, 1'b0, 1'b0, 8'd0, 8'd0);

        accept_op(0, 1'b0, 8'd200, 8'd7);
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        #2;
        rst = 1'b1;
        #1;
        chk("midcalc_rst_ready", int'(rdy_o[0]), 1);
        chk("midcalc_rst_valid", int'(ovld[0]), 0);
        chk("midcalc_rst_quo", int'(quo[0]), 0);
        chk("midcalc_rst_rem", int'(rem[0]), 0);
        chk("midcalc_rst_dz", int'(dz[0]), 0);
        chk("midcalc_rst_ov", int'(ov[0]), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_op(0, 1'b0, 8'd255, 8'd16, 0);

        cg_rand = 1'b1;
        for (int k = 0; k < 3; k++) begin
            rnd_op(s, a, b);
            accept_op(k, s, a, b);
            for (int i = 0; i < 40; i++) begin
                wait_valid(k);
                repeat ($urandom % 3) begin
                    @(posedge clk);
                    #1;
                end
                rnd_op(s, a, b);
                bb = (i < 39) && (($urandom % 2) == 1);
                release_res(k, bb, s, a, b);
                if (!bb && i < 39) accept_op(k, s, a, b);
            end
        end
        cg_rand = 1'b0;
        repeat (5) @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
